// File: rtl/lcv_mul32_seq.sv
// lcv_mul32_seq: sequential 32x32 -> 64-bit multiplier.
// Four 16x16 unsigned partial products are accumulated, one per cycle, in a
// registered MAC stage. A one-cycle correction step then turns the unsigned
// product into the two's-complement product for signed operations.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. The input side is ready only in IDLE. The output side
// presents a product in DONE and holds it until outp_ready is seen high.
module lcv_mul32_seq #(
   parameter int WIDTH      = 32,
   parameter int PROD_WIDTH = 2 * WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inp_valid,
   output logic                  inp_ready,
   input  logic [WIDTH-1:0]      inp_a,
   input  logic [WIDTH-1:0]      inp_b,
   input  logic                  inp_signed,
   output logic                  outp_valid,
   input  logic                  outp_ready,
   output logic [PROD_WIDTH-1:0] outp_prod,
   output logic                  outp_busy,
   output logic [1:0]            o_dbg_state
);

   localparam int HW = WIDTH / 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_CORR = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                r_state;
   logic [WIDTH-1:0]      r_a;
   logic [WIDTH-1:0]      r_b;
   logic                  r_signed;
   logic [1:0]            r_k;
   logic [PROD_WIDTH-1:0] r_acc;
   logic [PROD_WIDTH-1:0] r_prod;
   logic                  r_inp_ready;
   logic                  r_outp_valid;
   logic                  r_outp_busy;

   logic                  w_accept;
   logic [HW-1:0]         w_a_h;
   logic [HW-1:0]         w_b_h;
   logic [WIDTH-1:0]      w_pp;
   logic [PROD_WIDTH-1:0] w_pp_shifted;
   logic [PROD_WIDTH-1:0] w_corr_a;
   logic [PROD_WIDTH-1:0] w_corr_b;
   logic [PROD_WIDTH-1:0] w_corrected;

   assign w_accept = inp_valid && (r_state == S_IDLE);

   // Half-word selection: k[0] picks the half of a, k[1] picks the half of b.
   assign w_a_h = r_k[0] ? r_a[WIDTH-1:HW] : r_a[HW-1:0];
   assign w_b_h = r_k[1] ? r_b[WIDTH-1:HW] : r_b[HW-1:0];
   assign w_pp  = w_a_h * w_b_h;

   // Place the partial product at bit 0, HW or 2*HW depending on k[0]+k[1].
   always_comb begin
      w_pp_shifted = '0;
      case (r_k)
         2'd0:        w_pp_shifted = {{WIDTH{1'b0}}, w_pp};
         2'd1, 2'd2:  w_pp_shifted = {{HW{1'b0}}, w_pp, {HW{1'b0}}};
         default:     w_pp_shifted = {w_pp, {WIDTH{1'b0}}};
      endcase
   end

   // Signed fix-up: subtract b<<32 when a is negative and a<<32 when b is negative.
   assign w_corr_a    = r_a[WIDTH-1] ? {r_b, {WIDTH{1'b0}}} : '0;
   assign w_corr_b    = r_b[WIDTH-1] ? {r_a, {WIDTH{1'b0}}} : '0;
   assign w_corrected = r_signed ? (r_acc - w_corr_a - w_corr_b) : r_acc;

   // MAC datapath: clear on accept, accumulate in MUL, correct in CORR.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) r_acc <= '0;
            S_MUL:  r_acc <= r_acc + w_pp_shifted;
            S_CORR: r_acc <= w_corrected;
            default: r_acc <= r_acc;
         endcase
      end
   end

   // Control FSM with registered handshake flags, operand capture and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_signed     <= 1'b0;
         r_k          <= 2'd0;
         r_prod       <= '0;
         r_inp_ready  <= 1'b1;
         r_outp_valid <= 1'b0;
         r_outp_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a          <= inp_a;
                  r_b          <= inp_b;
                  r_signed     <= inp_signed;
                  r_k          <= 2'd0;
                  r_state      <= S_MUL;
                  r_inp_ready  <= 1'b0;
                  r_outp_busy  <= 1'b1;
               end
            end
            S_MUL: begin
               r_k <= r_k + 2'd1;
               if (r_k == 2'd3) begin
                  r_state <= S_CORR;
               end
            end
            S_CORR: begin
               r_prod       <= w_corrected;
               r_state      <= S_DONE;
               r_outp_valid <= 1'b1;
               r_outp_busy  <= 1'b0;
            end
            default: begin
               // DONE: result held until the consumer takes it.
               if (outp_ready) begin
                  r_state      <= S_IDLE;
                  r_outp_valid <= 1'b0;
                  r_inp_ready  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign inp_ready   = r_inp_ready;
   assign outp_valid  = r_outp_valid;
   assign outp_busy   = r_outp_busy;
   assign outp_prod   = r_prod;
   assign o_dbg_state = r_state;

endmodule

// File: doc/lcv_mul32_seq.md
Name: lcv_mul32_seq

Overview:
- Sequential 32x32 -> 64-bit multiplier that sits directly upstream of the ALU/MAC writeback path.
- Iterates four 16x16 unsigned partial products through a single registered multiply-accumulate stage, one per cycle.
- Applies a final correction step when the operation is signed.
- Uses a valid/ready handshake on both sides, so the CPU issue logic can stall on it.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; the half-word width is WIDTH/2 = 16.
- PROD_WIDTH, 2*WIDTH, product width (64).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- inp_valid  in  1  operand set valid.
- inp_ready  out  1  block can accept an operand set.
- inp_a  in  WIDTH  multiplicand.
- inp_b  in  WIDTH  multiplier.
- inp_signed  in  1  1 = treat inp_a/inp_b as two's complement; 0 = unsigned.
- outp_valid  out  1  outp_prod holds a finished product.
- outp_ready  in  1  consumer accepts outp_prod.
- outp_prod  out  PROD_WIDTH  product; full 64 bits, wraps mod 2^64.
- outp_busy  out  1  high in MUL or CORR.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, outp_valid=0, outp_prod=0, internal accumulator=0, pp index=0. Reset overrides every other input on that edge.
- FSM states: IDLE, MUL, CORR, DONE.
  - inp_ready = (state==IDLE).
  - outp_valid = (state==DONE).
  - outp_busy = (state==MUL or CORR).
- IDLE:
  - Accept occurs when inp_valid && inp_ready at an edge.
  - On accept: latch inp_a, inp_b and inp_signed into operand regs; clear the accumulator; set k=0; go to MUL.
  - Otherwise stay in IDLE.
- MUL: one partial product per edge, k = 0..3.
  - a_h = a[16*k[0] +: 16], b_h = b[16*k[1] +: 16].
  - acc <= acc + ({48'b0, a_h*b_h} << (16*(k[0]+k[1]))).
  - a_h*b_h is a 32-bit unsigned product; the add is modulo 2^64.
  - After k=3 is accumulated, go to CORR.
- CORR: one cycle.
  - If the latched signed flag = 1: acc <= acc - (a[31] ? {b,32'b0} : 0) - (b[31] ? {a,32'b0} : 0), modulo 2^64.
  - If unsigned: acc is unchanged.
  - outp_prod <= corrected value; go to DONE.
- DONE:
  - outp_prod is held stable while outp_valid=1 and outp_ready=0.
  - On outp_ready=1 at an edge: go to IDLE.
  - outp_prod keeps its last value after the handoff; only reset clears it.
- Latency: accept at edge N; partial products at edges N+1..N+4; correction at N+5; outp_valid=1 from N+5 until handoff. Minimum issue interval is 7 cycles (back-to-back with outp_ready=1).
- Simultaneous events:
  - inp_valid is ignored outside IDLE; there is no new accept in the same edge as a DONE handoff.
  - outp_ready is ignored outside DONE.
- Operand regs are captured only on accept. Changes on inp_a/inp_b/inp_signed mid-operation have no effect.
- Reset mid-operation (MUL/CORR/DONE): the result is discarded and the block returns to IDLE with outp_valid=0 at the next edge. There is no spurious outp_valid after reset.
- The MAC stage is a separate registered datapath (synthesis may map it to a DSP). The FSM must not use the accumulator value combinationally for control.

Test Plan:
- Unsigned max: inp_signed=0, a=b=0xFFFFFFFF -> outp_prod=0xFFFFFFFE00000001, outp_valid rises exactly 5 edges after accept.
- Signed small: inp_signed=1, a=0xFFFFFFFD (-3), b=0x00000005 -> outp_prod=0xFFFFFFFFFFFFFFF1 (-15). Also a=b=0xFFFFFFFF signed -> 0x0000000000000001.
- Signed corner: inp_signed=1, a=b=0x80000000 -> 0x4000000000000000. The same operands unsigned -> 0x4000000000000000; the a=0x80000000, b=0x7FFFFFFF signed case -> 0xC000000080000000.
- Backpressure: hold outp_ready=0 for 10 cycles after outp_valid -> outp_prod stable, inp_ready=0 throughout. Raise outp_ready -> inp_ready=1 on the next cycle; a new accept occurs no earlier than that.
- Operand isolation: change inp_a/inp_b every cycle during MUL while inp_valid=1 -> result matches the operands latched at accept (a=0x00010000, b=0x00010000 -> 0x0000000100000000); no second accept before handoff.
- Reset mid-op: assert rst for 1 cycle at accept+2 -> next cycle state IDLE, outp_valid=0, outp_prod=0, inp_ready=1. A fresh operation afterwards produces the correct product.
